// File: rtl/bcd_to_binary_pkg.sv
// Shared types and helpers for the packed-BCD to binary converter.
//   state_e   : converter FSM states
//   shifts_f  : number of shift cycles for a given digit count
//   cnt_w_f   : width of the shift counter for a given digit count
//   digit_ok  : legal-decimal-digit check for one nibble
package bcd_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

   localparam int DIGITS_DEF = 4;
   localparam int SHIFTS_DEF = 4 * DIGITS_DEF;

   function automatic int shifts_f(input int digits);
      return 4 * digits;
   endfunction

   // Counter must hold 0..SHIFTS inclusive.
   function automatic int cnt_w_f(input int digits);
      return $clog2(4 * digits + 1);
   endfunction

   function automatic logic digit_ok(input logic [3:0] d);
      return (d <= 4'd9);
   endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Request/response bundle for bcd_to_binary.
//   start/bcd           : requester -> converter
//   busy/done/bin/err   : converter -> requester
interface bcd_to_binary_if #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
);
   logic                  start;
   logic [4*DIGITS-1:0]   bcd;
   logic                  busy;
   logic                  done;
   logic [BIN_W-1:0]      bin;
   logic                  err;

   modport master (output start, bcd, input busy, done, bin, err);
   modport slave  (input start, bcd, output busy, done, bin, err);
endinterface

// File: rtl/bcd_digit_adjust.sv
// One-digit correction step of reverse double-dabble.
//   din  : digit after the right shift
//   dout : din - 3 when din >= 8, else din
module bcd_digit_adjust (
   input  logic [3:0] din,
   output logic [3:0] dout
);
   assign dout = din[3] ? (din - 4'd3) : din;
endmodule

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
//   CLOCK_50 : clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   bus      : slave side of bcd_to_binary_if (start/bcd in, busy/done/bin/err out)
// One right shift per clock over {bcd_part, bin_part}; after 4*DIGITS shifts
// bin_part holds the binary value. Invalid digits short-circuit to DONE.
module bcd_to_binary
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic            CLOCK_50,
   input  logic            RESET_N,
   bcd_to_binary_if.slave  bus
);
   localparam int NW     = 4 * DIGITS;
   localparam int SHIFTS = shifts_f(DIGITS);
   localparam int CNT_W  = cnt_w_f(DIGITS);

   state_e              state_q, state_d;
   logic [2*NW-1:0]     sr_q, sr_d;
   logic [2*NW-1:0]     sr_shr, sr_adj;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_pend_q, err_pend_d;
   logic [BIN_W-1:0]    bin_q, bin_d;
   logic                err_q, err_d;
   logic                done_q, done_d;
   logic                all_ok;

   // Shift first, then correct each BCD digit independently.
   assign sr_shr = sr_q >> 1;
   assign sr_adj[NW-1:0] = sr_shr[NW-1:0];

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .din  (sr_shr[NW+4*g +: 4]),
         .dout (sr_adj[NW+4*g +: 4])
      );
   end

   always_comb begin
      all_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++)
         if (!digit_ok(bus.bcd[4*i +: 4])) all_ok = 1'b0;
   end

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      cnt_d      = cnt_q;
      err_pend_d = err_pend_q;
      bin_d      = bin_q;
      err_d      = err_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               cnt_d = '0;
               if (!all_ok) begin
                  err_pend_d = 1'b1;
                  sr_d       = '0;
                  state_d    = DONE;
               end else begin
                  err_pend_d = 1'b0;
                  sr_d       = {bus.bcd, {NW{1'b0}}};
                  state_d    = SHIFT;
               end
            end
         end
         SHIFT: begin
            sr_d  = sr_adj;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SHIFTS - 1)) state_d = DONE;
         end
         DONE: begin
            // Result registers update only here, so done and bin/err align.
            bin_d   = err_pend_q ? '0 : sr_q[BIN_W-1:0];
            err_d   = err_pend_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         sr_q       <= '0;
         cnt_q      <= '0;
         err_pend_q <= 1'b0;
         bin_q      <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         err_pend_q <= err_pend_d;
         bin_q      <= bin_d;
         err_q      <= err_d;
         done_q     <= done_d;
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
   assign bus.bin  = bin_q;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed cases, random single
// conversions and a back-to-back stream against a decimal reference model.
module tb_bcd_to_binary;
   localparam int DIGITS = 4;
   localparam int BIN_W  = 14;
   localparam int SHIFTS = 4 * DIGITS;

   logic CLOCK_50 = 1'b0;
   logic RESET_N;
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;
   int   last_v   = 0;
   int   last_e   = 0;

   bcd_to_binary_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

   bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .bus      (bus)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(negedge CLOCK_50)
      if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
      cyc++;
   endtask

   // Decimal value of a packed BCD word; any nibble > 9 flags an error.
   task automatic ref_model(input logic [15:0] b, output int v, output int e);
      v = 0;
      e = 0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         int d;
         d = int'((b >> (4 * i)) & 16'hF);
         if (d > 9) e = 1;
         v = v * 10 + d;
      end
      if (e != 0) v = 0;
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int t;
      r = '0;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic wait_done(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.done !== 1'b1 && n < limit);
   endtask

   task automatic run_conv(input logic [15:0] b, input string tag);
      int v, e, n;
      ref_model(b, v, e);
      bus.bcd   = b;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check({tag, " busy"}, bus.busy, 1);
      check({tag, " bin held"}, bus.bin, last_v);
      wait_done(40, n);
      check({tag, " latency"}, n, (e != 0) ? 1 : SHIFTS + 1);
      check({tag, " bin"}, bus.bin, v);
      check({tag, " err"}, bus.err, e);
      tick();
      check({tag, " busy after"}, bus.busy, 0);
      check({tag, " done pulse"}, bus.done, 0);
      last_v = v;
      last_e = e;
   endtask

   initial begin
      logic [15:0] items[$];
      int          exp_q[$];
      int          n, d0, idx, last_done, got;

      bus.start = 1'b0;
      bus.bcd   = '0;
      RESET_N   = 1'b0;
      repeat (3) tick();
      check("rst busy", bus.busy, 0);
      check("rst done", bus.done, 0);
      check("rst bin",  bus.bin,  0);
      check("rst err",  bus.err,  0);
      RESET_N = 1'b1;
      tick();

      run_conv(16'h1234, "c1234");
      run_conv(16'h9999, "c9999");
      run_conv(16'h0000, "c0000");
      run_conv(16'h0001, "c0001");
      run_conv(16'h1000, "c1000");
      run_conv(16'h12A4, "c12A4");
      run_conv(16'h0042, "c0042");

      // start re-pulsed mid-conversion with different data must be ignored
      bus.bcd   = 16'h0500;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      d0 = done_cnt;
      repeat (4) tick();
      bus.start = 1'b1;
      bus.bcd   = 16'h0777;
      tick();
      bus.start = 1'b0;
      wait_done(40, n);
      check("ign latency", n, SHIFTS + 1 - 5);
      check("ign bin", bus.bin, 500);
      check("ign err", bus.err, 0);
      repeat (20) tick();
      check("ign one done", done_cnt - d0, 1);
      check("ign idle", bus.busy, 0);
      last_v = 500;
      last_e = 0;

      // reset in the middle of SHIFT abandons the conversion
      bus.bcd   = 16'h1234;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (8) tick();
      d0 = done_cnt;
      #2 RESET_N = 1'b0;
      #1;
      check("mrst busy", bus.busy, 0);
      check("mrst done", bus.done, 0);
      check("mrst bin",  bus.bin,  0);
      check("mrst err",  bus.err,  0);
      repeat (3) tick();
      RESET_N = 1'b1;
      repeat (25) tick();
      check("mrst no done", done_cnt - d0, 0);
      last_v = 0;
      last_e = 0;
      run_conv(16'h0250, "c0250");

      // random raw words: mostly invalid digits, some valid
      for (int k = 0; k < 30; k++) run_conv(16'($urandom), "rnd raw");
      // random legal values
      for (int k = 0; k < 20; k++) run_conv(to_bcd($urandom_range(9999)), "rnd dec");

      // back-to-back stream with start held high
      for (int k = 0; k < 20; k++) items.push_back(to_bcd(k));
      for (int k = 9990; k <= 9999; k++) items.push_back(to_bcd(k));
      for (int k = 0; k < 200; k++) items.push_back(to_bcd($urandom_range(9999)));
      bus.bcd = items[0];
      exp_q.push_back(int'(to_bcd(0)) * 0);
      bus.start = 1'b1;
      idx = 1;
      got = 0;
      last_done = -1;
      while (got < items.size()) begin
         wait_done(40, n);
         if (bus.done !== 1'b1) begin
            check("stream timeout", 0, 1);
            break;
         end
         got++;
         check("stream bin", bus.bin, exp_q.pop_front());
         check("stream err", bus.err, 0);
         if (last_done >= 0) check("stream gap", cyc - last_done, SHIFTS + 2);
         last_done = cyc;
         if (idx < items.size()) begin
            int v, e;
            ref_model(items[idx], v, e);
            bus.bcd = items[idx];
            exp_q.push_back(v);
            idx++;
         end else begin
            bus.start = 1'b0;
         end
      end
      repeat (3) tick();
      check("stream idle", bus.busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
